sar_adc_ctrl: RTL and testbench

Digital successive-approximation controller for the on-chip SAR ADC. It sits directly upstream of the analog macro on the `ua` pins. It drives the sample switch and the capacitive-DAC code, and reads back the asynchronous comparator decision. Each finished conversion is delivered as a WIDTH-bit result over a valid/ready handshake to the digital side of the tile.

---
 rtl/sar_adc_ctrl.sv | 157 +++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller for the on-chip SAR ADC: drives the sample
// switch and capacitive-DAC trial code, resolves one bit per STEP cycles MSB first.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_in,
    input  logic             result_ready,
    output logic             busy,
    output logic             sample_en,
    output logic [WIDTH-1:0] dac_code,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             overrun
);

    localparam int STEP    = SETTLE_CYCLES + 2;
    localparam int CNT_MAX = (SAMPLE_CYCLES > STEP) ? SAMPLE_CYCLES : STEP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP - 1);
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [IDX_W-1:0]  bit_idx_reg, bit_idx_next;
    logic              busy_reg, busy_next;
    logic              sample_en_reg, sample_en_next;
    logic [WIDTH-1:0]  dac_code_reg, dac_code_next;
    logic [WIDTH-1:0]  result_reg, result_next;
    logic              result_valid_reg, result_valid_next;
    logic              overrun_reg, overrun_next;
    logic [1:0]        sync_reg;
    logic              cmp_s;
    logic [WIDTH-1:0]  decided_code;
    logic [WIDTH-1:0]  next_trial;

    assign cmp_s = sync_reg[1];

    // decided_code resolves the bit under test; next_trial also raises the next lower bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_trial
            assign decided_code[gi] = (bit_idx_reg == IDX_W'(gi)) ? cmp_s : dac_code_reg[gi];
            assign next_trial[gi]   = (int'(bit_idx_reg) == gi + 1) ? 1'b1 : decided_code[gi];
        end
    endgenerate

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        bit_idx_next      = bit_idx_reg;
        busy_next         = busy_reg;
        sample_en_next    = sample_en_reg;
        dac_code_next     = dac_code_reg;
        result_next       = result_reg;
        result_valid_next = result_valid_reg;
        overrun_next      = overrun_reg;

        if (result_valid_reg && result_ready) begin
            result_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = SAMPLE;
                    busy_next      = 1'b1;
                    sample_en_next = 1'b1;
                    cnt_next       = '0;
                end
            end
            SAMPLE: begin
                if (cnt_reg == SAMPLE_LAST) begin
                    state_next     = CONVERT;
                    sample_en_next = 1'b0;
                    dac_code_next  = MSB_CODE;
                    bit_idx_next   = IDX_MSB;
                    cnt_next       = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            CONVERT: begin
                if (cnt_reg == STEP_LAST) begin
                    cnt_next = '0;
                    if (bit_idx_reg != '0) begin
                        dac_code_next = next_trial;
                        bit_idx_next  = bit_idx_reg - IDX_W'(1);
                    end else begin
                        // A same-edge handshake frees the slot, so only an unacked result counts as overrun.
                        state_next        = IDLE;
                        busy_next         = 1'b0;
                        dac_code_next     = '0;
                        result_next       = decided_code;
                        result_valid_next = 1'b1;
                        if (result_valid_reg && !result_ready) begin
                            overrun_next = 1'b1;
                        end
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            bit_idx_reg      <= '0;
            busy_reg         <= 1'b0;
            sample_en_reg    <= 1'b0;
            dac_code_reg     <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            sync_reg         <= '0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            bit_idx_reg      <= bit_idx_next;
            busy_reg         <= busy_next;
            sample_en_reg    <= sample_en_next;
            dac_code_reg     <= dac_code_next;
            result_reg       <= result_next;
            result_valid_reg <= result_valid_next;
            overrun_reg      <= overrun_next;
            sync_reg         <= {sync_reg[0], cmp_in};
        end
    end

    assign busy         = busy_reg;
    assign sample_en    = sample_en_reg;
    assign dac_code     = dac_code_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl with an ideal combinational comparator (vin >= dac_code).
module tb_sar_adc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cmp_in;
    logic       result_ready;
    logic       busy;
    logic       sample_en;
    logic [7:0] dac_code;
    logic [7:0] result;
    logic       result_valid;
    logic       overrun;
    logic [7:0] vin;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] a5_seq [8];

    sar_adc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cmp_in       (cmp_in),
        .result_ready (result_ready),
        .busy         (busy),
        .sample_en    (sample_en),
        .dac_code     (dac_code),
        .result       (result),
        .result_valid (result_valid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;
    assign cmp_in = (vin >= dac_code);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sample_en"}, sample_en, 0);
        check({tag, "_dac"}, dac_code, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_valid"}, result_valid, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    // Called right after a negedge with the DUT idle; k counts edges since the start edge.
    task automatic conv(input string tag, input logic [7:0] v, input logic [7:0] exp_res,
                        input bit chk_seq, input int x1, input int x2);
        int done_k = 0;
        int se_cnt = 0;
        int busy_cnt = 0;
        logic [7:0] exp_dac;
        vin   = v;
        start = 1'b1;
        for (int k = 1; k <= 60 && done_k == 0; k++) begin
            @(negedge clk);
            if (k == 1 || k == x1 + 1 || k == x2 + 1) start = 1'b0;
            if (k == x1 || k == x2) start = 1'b1;
            se_cnt   += int'(sample_en);
            busy_cnt += int'(busy);
            if (k > 1 && !busy) done_k = k;
            if (chk_seq) begin
                if (k <= 4 || k >= 37) exp_dac = 8'h00;
                else exp_dac = a5_seq[(k - 5) / 4];
                check($sformatf("%s_dac_k%0d", tag, k), dac_code, exp_dac);
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, done_k, 37);
        check({tag, "_sample_cycles"}, se_cnt, 4);
        check({tag, "_busy_cycles"}, busy_cnt, 36);
        check({tag, "_valid"}, result_valid, 1);
        check({tag, "_result"}, result, exp_res);
        $display("[TB] conv %s vin=0x%02h result=0x%02h latency=%0d overrun=%0b",
                 tag, v, result, done_k, overrun);
    endtask

    task automatic ack(input string tag);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check({tag, "_ack_valid"}, result_valid, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise_cnt = 0;
        int rise_k [2];
        logic prev_valid;

        a5_seq[0] = 8'h80; a5_seq[1] = 8'hC0; a5_seq[2] = 8'hA0; a5_seq[3] = 8'hB0;
        a5_seq[4] = 8'hA8; a5_seq[5] = 8'hA4; a5_seq[6] = 8'hA6; a5_seq[7] = 8'hA5;
        rise_k[0] = 0;
        rise_k[1] = 0;

        // Reset held two cycles with start high: nothing may start.
        rst = 1'b1; start = 1'b1; result_ready = 1'b0; vin = 8'h00;
        @(negedge clk);
        check("rst1_sample_en", sample_en, 0);
        @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_release_busy", busy, 0);
        check("rst_release_sample_en", sample_en, 0);

        // Full trace of the vin = 0xA5 conversion.
        conv("a5", 8'hA5, 8'hA5, 1'b1, 0, 0);
        check("a5_overrun", overrun, 0);
        ack("a5");

        // Extremes, each acknowledged with a single ready cycle.
        conv("zero", 8'h00, 8'h00, 1'b0, 0, 0);
        ack("zero");
        conv("full", 8'hFF, 8'hFF, 1'b0, 0, 0);
        ack("full");
        check("full_overrun", overrun, 0);

        // Backpressure: second result overwrites the first and flags overrun.
        conv("bp12", 8'h12, 8'h12, 1'b0, 0, 0);
        check("bp12_overrun", overrun, 0);
        conv("bp34", 8'h34, 8'h34, 1'b0, 0, 0);
        check("bp34_overrun", overrun, 1);
        ack("bp34");
        check("bp34_overrun_sticky", overrun, 1);

        // Abort ten cycles into a conversion.
        vin = 8'hFF; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        @(negedge clk);
        check("abort_after_valid", result_valid, 0);
        check("abort_after_busy", busy, 0);
        conv("5a", 8'h5A, 8'h5A, 1'b0, 0, 0);
        ack("5a");

        // Start pulses during a busy conversion are ignored, not queued.
        conv("ign", 8'h3C, 8'h3C, 1'b0, 5, 20);
        repeat (3) @(negedge clk);
        check("ign_no_requeue_busy", busy, 0);
        check("ign_no_requeue_sample", sample_en, 0);
        ack("ign");

        // Start held high: completions repeat every 37 cycles.
        vin = 8'h77; result_ready = 1'b1; start = 1'b1;
        prev_valid = result_valid;
        for (int k = 1; k <= 100 && rise_cnt < 2; k++) begin
            @(negedge clk);
            if (result_valid && !prev_valid) begin
                rise_k[rise_cnt] = k;
                rise_cnt++;
                check($sformatf("held_result_%0d", rise_cnt), result, 8'h77);
            end
            prev_valid = result_valid;
        end
        start = 1'b0;
        check("held_rise_count", rise_cnt, 2);
        check("held_first_rise", rise_k[0], 37);
        check("held_period", rise_k[1] - rise_k[0], 37);
        $display("[TB] held start: valid rises at k=%0d and k=%0d", rise_k[0], rise_k[1]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
